// File: rtl/instruction_loader_if.sv
// instruction_loader_if: byte-stream-in / imem-write-out bundle of the program loader.
// Ports: i_start, i_rx_data, i_rx_valid (debug unit / UART -> loader);
//        o_imem_wr_en, o_imem_addr, o_imem_data, o_busy, o_done, o_error, o_word_count (loader -> memory / debug unit).
interface instruction_loader_if #(
  parameter int NB      = 32,
  parameter int NB_BYTE = 8,
  parameter int NB_ADDR = 10
);
  logic               i_start;
  logic [NB_BYTE-1:0] i_rx_data;
  logic               i_rx_valid;
  logic               o_imem_wr_en;
  logic [NB_ADDR-1:0] o_imem_addr;
  logic [NB-1:0]      o_imem_data;
  logic               o_busy;
  logic               o_done;
  logic               o_error;
  logic [NB_ADDR:0]   o_word_count;
  modport master (
    output i_start, i_rx_data, i_rx_valid,
    input  o_imem_wr_en, o_imem_addr, o_imem_data, o_busy, o_done, o_error, o_word_count
  );
  modport slave (
    input  i_start, i_rx_data, i_rx_valid,
    output o_imem_wr_en, o_imem_addr, o_imem_data, o_busy, o_done, o_error, o_word_count
  );
endinterface

// File: rtl/instruction_loader.sv
// instruction_loader: assembles big-endian 32-bit words from UART bytes and writes them to
// consecutive instruction-memory addresses until the HALT word is written.
// Ports: i_clk, i_reset_n (sync, active-low); bus (slave): start/byte stream in,
//        imem write port, busy/done/error status and written-word count out.
module instruction_loader #(
  parameter int              NB        = 32,
  parameter int              NB_BYTE   = 8,
  parameter int              NB_ADDR   = 10,
  parameter logic [NB-1:0]   HALT_WORD = 32'hFFFF_FFFF
) (
  input logic                 i_clk,
  input logic                 i_reset_n,
  instruction_loader_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERROR} state_t;
  state_t               state_q;
  logic [1:0]           idx_q;
  logic [NB_ADDR-1:0]   addr_q;
  logic [NB-NB_BYTE-1:0] buf_q;
  logic                 wr_en_q;
  logic [NB-1:0]        data_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 err_q;
  logic [NB_ADDR:0]     count_q;
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      buf_q   <= '0;
      wr_en_q <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        IDLE, DONE, ERROR: if (bus.i_start) begin
          state_q <= RECV;
          idx_q   <= '0;
          addr_q  <= '0;
          count_q <= '0;
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
        end
        RECV: if (bus.i_rx_valid) begin
          // Bytes shift in from the bottom, so after three bytes the first one sits at the top.
          buf_q <= {buf_q[NB-2*NB_BYTE-1:0], bus.i_rx_data};
          idx_q <= idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_q <= WRITE;
            wr_en_q <= 1'b1;
            data_q  <= {buf_q, bus.i_rx_data};
          end
        end
        WRITE: begin
          count_q <= count_q + (NB_ADDR+1)'(1);
          if (data_q == HALT_WORD) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (&addr_q) begin
            state_q <= ERROR;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            state_q <= RECV;
            addr_q  <= addr_q + NB_ADDR'(1);
          end
          // A byte arriving during the write cycle is byte 0 of the next word.
          if (bus.i_rx_valid) begin
            buf_q <= {buf_q[NB-2*NB_BYTE-1:0], bus.i_rx_data};
            idx_q <= 2'd1;
          end else begin
            idx_q <= 2'd0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.o_imem_wr_en = wr_en_q;
  assign bus.o_imem_addr  = addr_q;
  assign bus.o_imem_data  = data_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_done       = done_q;
  assign bus.o_error      = err_q;
  assign bus.o_word_count = count_q;
endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader: directed + randomized loads checked against a word-list model of the loader.
module tb_instruction_loader;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       rst_n, start, rx_valid, sel;
  logic [7:0] rx_data;
  instruction_loader_if #(.NB(32), .NB_BYTE(8), .NB_ADDR(10)) ifa();
  instruction_loader_if #(.NB(32), .NB_BYTE(8), .NB_ADDR(2))  ifb();
  instruction_loader #(.NB(32), .NB_BYTE(8), .NB_ADDR(10)) dut_a (.i_clk(clk), .i_reset_n(rst_n), .bus(ifa));
  instruction_loader #(.NB(32), .NB_BYTE(8), .NB_ADDR(2))  dut_b (.i_clk(clk), .i_reset_n(rst_n), .bus(ifb));
  assign ifa.i_start    = start & ~sel;
  assign ifa.i_rx_valid = rx_valid & ~sel;
  assign ifa.i_rx_data  = rx_data;
  assign ifb.i_start    = start & sel;
  assign ifb.i_rx_valid = rx_valid & sel;
  assign ifb.i_rx_data  = rx_data;
  logic        wr_en, busy, done, err;
  logic [9:0]  addr;
  logic [31:0] data;
  logic [10:0] cnt;
  assign wr_en = sel ? ifb.o_imem_wr_en : ifa.o_imem_wr_en;
  assign addr  = sel ? {8'b0, ifb.o_imem_addr} : ifa.o_imem_addr;
  assign data  = sel ? ifb.o_imem_data : ifa.o_imem_data;
  assign busy  = sel ? ifb.o_busy : ifa.o_busy;
  assign done  = sel ? ifb.o_done : ifa.o_done;
  assign err   = sel ? ifb.o_error : ifa.o_error;
  assign cnt   = sel ? {8'b0, ifb.o_word_count} : ifa.o_word_count;
  int          wa[$];
  logic [31:0] wd[$];
  always @(negedge clk) if (wr_en) begin
    wa.push_back(int'(addr));
    wd.push_back(data);
  end
  int          errors = 0, checks = 0;
  logic [7:0]  prog[$];
  int          exp_a[$];
  logic [31:0] exp_d[$];
  logic        exp_done, exp_err;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b, input int gap, input bit noise);
    rx_data  = b;
    rx_valid = 1'b1;
    start    = noise ? 1'($urandom) : 1'b0;
    tick();
    rx_valid = 1'b0;
    start    = 1'b0;
    rx_data  = 8'($urandom);
    repeat (gap) tick();
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) begin
      start    = 1'($urandom);
      rx_valid = 1'($urandom);
      rx_data  = 8'($urandom);
      tick();
    end
    rst_n = 1'b1;
    start = 1'b0;
    rx_valid = 1'b0;
  endtask
  // Reference: split the accepted bytes into big-endian words; stop at HALT or at the last address.
  task automatic model(input int depth);
    logic [31:0] w;
    int a;
    a = 0;
    exp_a.delete();
    exp_d.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    for (int i = 0; i + 3 < prog.size(); i += 4) begin
      w = {prog[i], prog[i+1], prog[i+2], prog[i+3]};
      exp_a.push_back(a);
      exp_d.push_back(w);
      if (w == 32'hFFFF_FFFF) begin exp_done = 1'b1; break; end
      if (a == depth - 1) begin exp_err = 1'b1; break; end
      a++;
    end
  endtask
  task automatic rand_prog(input int nw);
    logic [31:0] w;
    prog.delete();
    for (int k = 0; k < nw; k++) begin
      w = $urandom;
      if (w == 32'hFFFF_FFFF) w = 32'h0;
      for (int j = 3; j >= 0; j--) prog.push_back(w[j*8 +: 8]);
    end
    repeat (4) prog.push_back(8'hFF);
  endtask
  // gap < 0 picks a random 0..2 cycle gap per byte.
  task automatic do_load(input int gap, input bit noise, input bit start_byte);
    wa.delete();
    wd.delete();
    start = 1'b1;
    if (start_byte) begin
      rx_valid = 1'b1;
      rx_data  = 8'h11;
    end
    tick();
    start = 1'b0;
    rx_valid = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("done_cleared", done, 0);
    chk("err_cleared", err, 0);
    chk("count_cleared", cnt, 0);
    foreach (prog[i]) send(prog[i], gap < 0 ? int'($urandom_range(2, 0)) : gap, noise);
    repeat (3) tick();
    model(sel ? 4 : 1024);
    chk("num_writes", wa.size(), exp_a.size());
    for (int i = 0; i < exp_a.size(); i++) if (i < wa.size()) begin
      chk("wr_addr", wa[i], exp_a[i]);
      chk("wr_data", wd[i], exp_d[i]);
    end
    chk("done", done, exp_done);
    chk("error", err, exp_err);
    chk("busy_end", busy, 0);
    chk("word_count", cnt, exp_a.size());
    repeat (4) send(8'($urandom), 0, 1'b0);
    repeat (2) tick();
    chk("no_write_after_end", wa.size(), exp_a.size());
    chk("status_hold", {done, err}, {exp_done, exp_err});
  endtask
  initial begin
    sel = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h0; rst_n = 1'b1;
    tick();
    do_reset();
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      chk("rst_outputs", {wr_en, addr, data, busy, done, err, cnt}, 0);
    end
    sel = 1'b0;
    prog = '{8'h20, 8'h01, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    do_load(1, 1'b0, 1'b0);
    prog = '{8'h8C, 8'h22, 8'h00, 8'h04, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    do_load(0, 1'b0, 1'b0);
    sel = 1'b1;
    #1;
    prog.delete();
    repeat (16) prog.push_back(8'h00);
    do_load(-1, 1'b0, 1'b0);
    rand_prog(1);
    do_load(0, 1'b0, 1'b1);
    sel = 1'b0;
    #1;
    wa.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    send(8'hAA, 0, 1'b0);
    send(8'hBB, 0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_reset_busy", busy, 0);
    chk("mid_reset_nowrite", wa.size(), 0);
    prog = '{8'h00, 8'h00, 8'h00, 8'h20, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    do_load(1, 1'b0, 1'b0);
    do_reset();
    wa.delete();
    repeat (4) send(8'($urandom), 0, 1'b0);
    tick();
    chk("idle_bytes_nowrite", wa.size(), 0);
    chk("idle_bytes_busy", busy, 0);
    rand_prog(3);
    do_load(-1, 1'b1, 1'b0);
    rand_prog(2);
    do_load(0, 1'b1, 1'b1);
    for (int r = 0; r < 8; r++) begin
      sel = 1'($urandom);
      #1;
      rand_prog(int'($urandom_range(5, 0)));
      do_load(-1, 1'($urandom), 1'($urandom));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
